// File: rtl/multi_cycle_cpu_io_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, funcs,
// FSM encoding and the default reset vector.
package multi_cycle_cpu_io_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// 31x32 register file; $0 is hardwired zero. Two async read ports, one
// synchronous write port, synchronous clear of every register.
module mcpu_regfile (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [1:31];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : regs_q[ra2_i];

endmodule

// File: rtl/multi_cycle_cpu_io.sv
// Multi-cycle MIPS-subset core with a single shared memory/I-O port.
// FETCH -> EXEC -> (MEM) -> FETCH; faults park the core in HALT until clr.
module multi_cycle_cpu_io
  import multi_cycle_cpu_io_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter bit          EN_BYTE  = 1'b1,
  parameter bit          EN_SLT   = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  output logic [31:0] m_addr,
  output logic        m_req,
  output logic        m_write,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic [31:0] d_f_mem,
  output logic [31:0] d_t_mem,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] retired
);

  state_e      state_q;
  logic [31:0] pc_q, ir_q, addr_q, sdata_q, retired_q;
  logic [3:0]  be_q;
  logic        write_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] a, b, simm, zimm, pc4, ea;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];
  assign simm  = sext16(imm);
  assign zimm  = {16'h0, imm};
  assign pc4   = pc_q + 32'd4;
  assign ea    = a + simm;

  logic        ex_illegal, ex_mem, ex_store, ex_we;
  logic [4:0]  ex_wa;
  logic [31:0] ex_wd, ex_pc, ex_sdata;
  logic [3:0]  ex_be;

  always_comb begin
    ex_illegal = 1'b0;
    ex_mem     = 1'b0;
    ex_store   = 1'b0;
    ex_we      = 1'b0;
    ex_wa      = rt;
    ex_wd      = 32'h0;
    ex_pc      = pc4;
    ex_be      = 4'hF;
    ex_sdata   = b;
    case (op)
      OP_RTYPE: begin
        ex_wa = rd;
        ex_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ex_wd = a + b;
          FN_SUB:  ex_wd = a - b;
          FN_AND:  ex_wd = a & b;
          FN_OR:   ex_wd = a | b;
          FN_XOR:  ex_wd = a ^ b;
          FN_SLL:  ex_wd = b << shamt;
          FN_SRL:  ex_wd = b >> shamt;
          FN_SRA:  ex_wd = $signed(b) >>> shamt;
          FN_SLT:  begin
            ex_wd      = {31'h0, $signed(a) < $signed(b)};
            ex_illegal = !EN_SLT;
          end
          FN_JR:   begin
            ex_we = 1'b0;
            ex_pc = a;
          end
          default: ex_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin ex_we = 1'b1; ex_wd = a + simm; end
      OP_ANDI: begin ex_we = 1'b1; ex_wd = a & zimm; end
      OP_ORI:  begin ex_we = 1'b1; ex_wd = a | zimm; end
      OP_XORI: begin ex_we = 1'b1; ex_wd = a ^ zimm; end
      OP_LUI:  begin ex_we = 1'b1; ex_wd = {imm, 16'h0}; end
      OP_SLTI: begin
        ex_we      = 1'b1;
        ex_wd      = {31'h0, $signed(a) < $signed(simm)};
        ex_illegal = !EN_SLT;
      end
      OP_BEQ:  if (a == b) ex_pc = pc4 + (simm << 2);
      OP_BNE:  if (a != b) ex_pc = pc4 + (simm << 2);
      OP_J:    ex_pc = {pc4[31:28], ir_q[25:0], 2'b00};
      OP_JAL:  begin
        ex_pc = {pc4[31:28], ir_q[25:0], 2'b00};
        ex_we = 1'b1;
        ex_wa = 5'd31;
        ex_wd = pc4;
      end
      OP_LW:   begin ex_mem = 1'b1; ex_illegal = (ea[1:0] != 2'b00); end
      OP_SW:   begin
        ex_mem     = 1'b1;
        ex_store   = 1'b1;
        ex_illegal = (ea[1:0] != 2'b00);
      end
      OP_LB, OP_LBU: begin ex_mem = 1'b1; ex_illegal = !EN_BYTE; end
      OP_SB:   begin
        ex_mem     = 1'b1;
        ex_store   = 1'b1;
        ex_be      = 4'b0001 << ea[1:0];
        ex_sdata   = {4{b[7:0]}};
        ex_illegal = !EN_BYTE;
      end
      default: ex_illegal = 1'b1;
    endcase
  end

  // Load return path: pick the addressed lane, then extend per opcode.
  logic [31:0] lane_sh, ld_data;
  assign lane_sh = d_f_mem >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (op)
      OP_LB:   ld_data = {{24{lane_sh[7]}}, lane_sh[7:0]};
      OP_LBU:  ld_data = {24'h0, lane_sh[7:0]};
      default: ld_data = d_f_mem;
    endcase
  end

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  assign rf_we = ((state_q == S_EXEC) && ex_we && !ex_illegal) ||
                 ((state_q == S_MEM) && m_ready && !write_q);
  assign rf_wa = (state_q == S_MEM) ? rt : ex_wa;
  assign rf_wd = (state_q == S_MEM) ? ld_data : ex_wd;

  mcpu_regfile u_rf (
    .clk   (clk),
    .clr   (clr),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (a),
    .rd2_o (b),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      retired_q <= 32'h0;
    end else begin
      case (state_q)
        S_FETCH: if (m_ready) begin
          ir_q    <= d_f_mem;
          state_q <= S_EXEC;
        end
        S_EXEC: if (ex_illegal) begin
          state_q <= S_HALT;
        end else if (ex_mem) begin
          addr_q  <= ea;
          sdata_q <= ex_sdata;
          be_q    <= ex_be;
          write_q <= ex_store;
          state_q <= S_MEM;
        end else begin
          pc_q      <= ex_pc;
          retired_q <= retired_q + 32'd1;
          state_q   <= S_FETCH;
        end
        S_MEM: if (m_ready) begin
          pc_q      <= pc4;
          retired_q <= retired_q + 32'd1;
          state_q   <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign m_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign m_write = (state_q == S_MEM) && write_q;
  assign m_be    = (state_q == S_FETCH) ? 4'hF : (state_q == S_MEM) ? be_q : 4'h0;
  assign m_addr  = (state_q == S_MEM) ? addr_q : pc_q;
  assign d_t_mem = sdata_q;
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_cpu_io.sv
// Directed bench for multi_cycle_cpu_io: a table of short programs plus
// hand-written sequences for wait states, faults and mid-request reset.
module tb_multi_cycle_cpu_io;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] m_addr, d_f_mem, d_t_mem, pc, retired;
  logic        m_req, m_write, m_ready, halted;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  multi_cycle_cpu_io dut (
    .clk     (clk),
    .clr     (clr),
    .m_addr  (m_addr),
    .m_req   (m_req),
    .m_write (m_write),
    .m_be    (m_be),
    .m_ready (m_ready),
    .d_f_mem (d_f_mem),
    .d_t_mem (d_t_mem),
    .pc      (pc),
    .halted  (halted),
    .retired (retired)
  );

  logic [31:0] mem [0:63];
  int fwait = 0;
  int dwait = 0;
  int cnt   = 0;
  bit fresh = 1'b1;

  initial begin
    m_ready = 1'b0;
    d_f_mem = 32'h0;
  end

  // Memory responder: each new request waits fwait/dwait cycles before ready.
  always @(negedge clk) begin
    if (m_ready || clr) fresh = 1'b1;
    if (!m_req) begin
      m_ready = 1'b0;
      fresh   = 1'b1;
    end else begin
      if (fresh) begin
        cnt   = ((m_addr == pc) && !m_write) ? fwait : dwait;
        fresh = 1'b0;
      end
      if (cnt > 0) begin
        m_ready = 1'b0;
        cnt     = cnt - 1;
      end else begin
        m_ready = 1'b1;
        d_f_mem = mem[m_addr[7:2]];
      end
    end
  end

  int          st_cnt = 0;
  logic [31:0] st_addr = 32'h0, st_data = 32'h0;
  logic [3:0]  st_be = 4'h0;
  always @(posedge clk) begin
    if (!clr && m_req && m_ready && m_write) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= m_addr;
      st_data <= d_t_mem;
      st_be   <= m_be;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.u_rf.regs_q[i];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] p2, input logic [31:0] p3);
    clr = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] p0, p1, p2, p3;
    int          cyc;
    int          ridx;
    logic [31:0] rval, pcx, retx;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input string nm, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input int cyc, input int ridx,
                              input logic [31:0] rval, input logic [31:0] pcx,
                              input logic [31:0] retx);
    vec_t v;
    v.name = nm; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = 32'h0;
    v.cyc = cyc; v.ridx = ridx; v.rval = rval; v.pcx = pcx; v.retx = retx;
    return v;
  endfunction

  initial begin
    int st0;
    clr = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32] = 32'h0080_0000;

    vecs[0]  = mk("prog_r2", enc_i(6'h08,5'd0,5'd1,16'h0005), enc_i(6'h08,5'd1,5'd2,16'hFFF9),
                  enc_r(5'd2,5'd1,5'd3,5'd0,6'h2A), 6, 2, 32'hFFFF_FFFE, 32'hC, 3);
    vecs[1]  = mk("prog_slt", enc_i(6'h08,5'd0,5'd1,16'h0005), enc_i(6'h08,5'd1,5'd2,16'hFFF9),
                  enc_r(5'd2,5'd1,5'd3,5'd0,6'h2A), 6, 3, 32'h1, 32'hC, 3);
    vecs[2]  = mk("lui_ori", enc_i(6'h0F,5'd0,5'd4,16'h1234), enc_i(6'h0D,5'd4,5'd4,16'h5678),
                  32'h0, 4, 4, 32'h1234_5678, 32'h8, 2);
    vecs[3]  = mk("sra", enc_i(6'h08,5'd0,5'd1,16'hFF00), enc_r(5'd0,5'd1,5'd2,5'd4,6'h03),
                  enc_r(5'd0,5'd1,5'd3,5'd4,6'h02), 6, 2, 32'hFFFF_FFF0, 32'hC, 3);
    vecs[4]  = mk("srl", enc_i(6'h08,5'd0,5'd1,16'hFF00), enc_r(5'd0,5'd1,5'd2,5'd4,6'h03),
                  enc_r(5'd0,5'd1,5'd3,5'd4,6'h02), 6, 3, 32'h0FFF_FFF0, 32'hC, 3);
    vecs[5]  = mk("lb", enc_i(6'h08,5'd0,5'd1,16'h0082), enc_i(6'h20,5'd1,5'd2,16'h0000),
                  32'h0, 5, 2, 32'hFFFF_FF80, 32'h8, 2);
    vecs[6]  = mk("lbu", enc_i(6'h08,5'd0,5'd1,16'h0082), enc_i(6'h24,5'd1,5'd2,16'h0000),
                  32'h0, 5, 2, 32'h0000_0080, 32'h8, 2);
    vecs[7]  = mk("lw", enc_i(6'h08,5'd0,5'd1,16'h0080), enc_i(6'h23,5'd1,5'd2,16'h0000),
                  32'h0, 5, 2, 32'h0080_0000, 32'h8, 2);
    vecs[8]  = mk("beq_self", enc_i(6'h04,5'd0,5'd0,16'hFFFF), 32'h0, 32'h0, 4, 0, 32'h0, 32'h0, 2);
    vecs[9]  = mk("bne_taken", enc_i(6'h08,5'd0,5'd1,16'h0001), enc_i(6'h05,5'd1,5'd0,16'h0002),
                  32'h0, 4, 1, 32'h1, 32'h10, 2);
    vecs[10] = mk("r0_discard", enc_i(6'h08,5'd0,5'd0,16'h0005), enc_r(5'd0,5'd0,5'd1,5'd0,6'h20),
                  32'h0, 4, 1, 32'h0, 32'h8, 2);
    vecs[11] = mk("sll", enc_i(6'h08,5'd0,5'd1,16'h0003), enc_r(5'd0,5'd1,5'd2,5'd4,6'h00),
                  32'h0, 4, 2, 32'h30, 32'h8, 2);
    vecs[12] = mk("slti", enc_i(6'h08,5'd0,5'd1,16'hFFFD), enc_i(6'h0A,5'd1,5'd2,16'hFFFE),
                  32'h0, 4, 2, 32'h1, 32'h8, 2);
    vecs[13] = mk("andi_zext", enc_i(6'h08,5'd0,5'd1,16'hFFFF), enc_i(6'h0C,5'd1,5'd2,16'h8001),
                  32'h0, 4, 2, 32'h0000_8001, 32'h8, 2);
    vecs[14] = mk("sub", enc_i(6'h08,5'd0,5'd1,16'h000A), enc_r(5'd0,5'd1,5'd2,5'd0,6'h22),
                  32'h0, 4, 2, 32'hFFFF_FFF6, 32'h8, 2);

    // Reset state
    tick(3);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_mreq", {31'h0, m_req}, 32'h1);
    chk("rst_mwrite", {31'h0, m_write}, 32'h0);
    chk("rst_mbe", {28'h0, m_be}, 32'hF);
    chk("rst_maddr", m_addr, 32'h0);

    foreach (vecs[k]) begin
      load(vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].p3);
      tick(vecs[k].cyc);
      if (vecs[k].ridx != 0) chk({vecs[k].name, "_reg"}, rf(vecs[k].ridx), vecs[k].rval);
      chk({vecs[k].name, "_pc"}, pc, vecs[k].pcx);
      chk({vecs[k].name, "_retired"}, retired, vecs[k].retx);
    end

    // jal from 0x40
    load(enc_j(6'h02, 26'h10), 32'h0, 32'h0, 32'h0);
    mem[16] = enc_j(6'h03, 26'h20);
    tick(4);
    chk("jal_r31", rf(31), 32'h44);
    chk("jal_pc", pc, 32'h80);

    // sb with three wait cycles
    dwait = 3;
    st0 = st_cnt;
    load(enc_i(6'h08,5'd0,5'd1,16'h0102), enc_i(6'h08,5'd0,5'd2,16'h00AB),
         enc_i(6'h28,5'd1,5'd2,16'h0001), 32'h0);
    tick(6);
    for (int c = 0; c < 4; c++) begin
      chk("sb_mreq", {31'h0, m_req}, 32'h1);
      chk("sb_mwrite", {31'h0, m_write}, 32'h1);
      chk("sb_maddr", m_addr, 32'h103);
      chk("sb_mbe", {28'h0, m_be}, 32'h8);
      chk("sb_data", d_t_mem, 32'hABAB_ABAB);
      chk("sb_pc_hold", pc, 32'h8);
      tick(1);
    end
    chk("sb_pc_after", pc, 32'hC);
    chk("sb_retired", retired, 32'h3);
    chk("sb_store_cnt", st_cnt - st0, 32'h1);
    chk("sb_store_addr", st_addr, 32'h103);
    chk("sb_store_be", {28'h0, st_be}, 32'h8);
    dwait = 0;

    // misaligned lw halts, then clr recovers
    load(enc_i(6'h08,5'd0,5'd1,16'h0006), enc_i(6'h23,5'd1,5'd2,16'h0000), 32'h0, 32'h0);
    tick(4);
    chk("lwmis_halted", {31'h0, halted}, 32'h1);
    chk("lwmis_pc", pc, 32'h4);
    chk("lwmis_retired", retired, 32'h1);
    tick(5);
    chk("lwmis_mreq", {31'h0, m_req}, 32'h0);
    chk("lwmis_r2", rf(2), 32'h0);
    @(negedge clk); clr = 1'b1;
    tick(1);
    chk("lwmis_clr_halted", {31'h0, halted}, 32'h0);
    @(negedge clk); clr = 1'b0;
    #1;
    chk("lwmis_refetch_req", {31'h0, m_req}, 32'h1);
    chk("lwmis_refetch_addr", m_addr, 32'h0);

    // illegal opcode 0x3F
    load(32'hFC00_0000, 32'h0, 32'h0, 32'h0);
    tick(2);
    chk("ill_halted", {31'h0, halted}, 32'h1);
    chk("ill_pc", pc, 32'h0);
    tick(5);
    chk("ill_mreq", {31'h0, m_req}, 32'h0);
    chk("ill_retired", retired, 32'h0);

    // clr during MEM of a stalled sw
    dwait = 5;
    st0 = st_cnt;
    load(enc_i(6'h2B,5'd0,5'd0,16'h0084), 32'h0, 32'h0, 32'h0);
    tick(3);
    chk("swclr_in_mem", {31'h0, m_write}, 32'h1);
    @(negedge clk); clr = 1'b1;
    tick(1);
    @(negedge clk); clr = 1'b0;
    #1;
    chk("swclr_retired", retired, 32'h0);
    chk("swclr_pc", pc, 32'h0);
    chk("swclr_fetch_addr", m_addr, 32'h0);
    chk("swclr_fetch_wr", {31'h0, m_write}, 32'h0);
    chk("swclr_no_store", st_cnt - st0, 32'h0);
    dwait = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
